// File: rtl/microsoc_pkg.sv
// Shared types for the data-bus arbiter: FSM state encoding and master indices.
package microsoc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef logic mst_idx_t;

    localparam mst_idx_t MST_CPU = 1'b0;
    localparam mst_idx_t MST_AUX = 1'b1;

endpackage

// File: rtl/data_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, on contention the master
// that was not served last wins.
module rr_pick2
    import microsoc_pkg::*;
(
    input  logic [1:0] req_i,
    input  mst_idx_t   last_i,
    output mst_idx_t   winner_o,
    output logic       valid_o
);

    // Combinational winner selection.
    always_comb begin
        winner_o = MST_CPU;
        valid_o  = |req_i;
        case (req_i)
            2'b01:   winner_o = MST_CPU;
            2'b10:   winner_o = MST_AUX;
            2'b11:   winner_o = (last_i == MST_CPU) ? MST_AUX : MST_CPU;
            default: winner_o = MST_CPU;
        endcase
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master to one-slave data bus arbiter with a single outstanding
// transaction. The request path is combinational (gnt follows s_data_gnt in
// the same cycle); responses are routed to the master that owns the
// transaction and are ignored outside the RESP state.
//
// state | meaning
// IDLE  | no transaction; winner picked combinationally from live requests
// HOLD  | request presented but not yet accepted; selection frozen in sel_q
// RESP  | transaction accepted; waiting for s_data_rvalid for owner_q
module data_bus_arbiter
    import microsoc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_data_req,
    input  logic              m0_data_we,
    input  logic [3:0]        m0_data_be,
    input  logic [ADDR_W-1:0] m0_data_addr,
    input  logic [DATA_W-1:0] m0_data_wdata,
    output logic              m0_data_gnt,
    output logic              m0_data_rvalid,
    output logic [DATA_W-1:0] m0_data_rdata,
    output logic              m0_data_err,

    input  logic              m1_data_req,
    input  logic              m1_data_we,
    input  logic [3:0]        m1_data_be,
    input  logic [ADDR_W-1:0] m1_data_addr,
    input  logic [DATA_W-1:0] m1_data_wdata,
    output logic              m1_data_gnt,
    output logic              m1_data_rvalid,
    output logic [DATA_W-1:0] m1_data_rdata,
    output logic              m1_data_err,

    output logic              s_data_req,
    output logic              s_data_we,
    output logic [3:0]        s_data_be,
    output logic [ADDR_W-1:0] s_data_addr,
    output logic [DATA_W-1:0] s_data_wdata,
    input  logic              s_data_gnt,
    input  logic              s_data_rvalid,
    input  logic [DATA_W-1:0] s_data_rdata,
    input  logic              s_data_err
);

    arb_state_t state_q;
    mst_idx_t   sel_q;
    mst_idx_t   owner_q;
    mst_idx_t   last_served_q;

    mst_idx_t   pick_winner;
    logic       pick_valid;
    mst_idx_t   cur_sel;
    logic       cur_req;
    logic       resp_fire;

    rr_pick2 u_rr_pick2 (
        .req_i    ({m1_data_req, m0_data_req}),
        .last_i   (last_served_q),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    // Request routing: live pick in IDLE, frozen selection in HOLD, nothing in RESP.
    always_comb begin
        cur_sel = (state_q == HOLD) ? sel_q : pick_winner;
        cur_req = 1'b0;
        case (state_q)
            IDLE:    cur_req = pick_valid;
            HOLD:    cur_req = (sel_q == MST_AUX) ? m1_data_req : m0_data_req;
            default: cur_req = 1'b0;
        endcase

        s_data_req   = cur_req;
        s_data_we    = (cur_sel == MST_AUX) ? m1_data_we    : m0_data_we;
        s_data_be    = (cur_sel == MST_AUX) ? m1_data_be    : m0_data_be;
        s_data_addr  = (cur_sel == MST_AUX) ? m1_data_addr  : m0_data_addr;
        s_data_wdata = (cur_sel == MST_AUX) ? m1_data_wdata : m0_data_wdata;

        m0_data_gnt = cur_req && (cur_sel == MST_CPU) && s_data_gnt;
        m1_data_gnt = cur_req && (cur_sel == MST_AUX) && s_data_gnt;
    end

    // Response routing: only the owner sees rvalid/err, and only while in RESP.
    always_comb begin
        resp_fire      = (state_q == RESP) && s_data_rvalid;
        m0_data_rvalid = resp_fire && (owner_q == MST_CPU);
        m1_data_rvalid = resp_fire && (owner_q == MST_AUX);
        m0_data_err    = m0_data_rvalid && s_data_err;
        m1_data_err    = m1_data_rvalid && s_data_err;
        m0_data_rdata  = s_data_rdata;
        m1_data_rdata  = s_data_rdata;
    end

    // Arbitration FSM; a master that drops its request while held releases the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_served_q <= MST_AUX;
            owner_q       <= MST_CPU;
            sel_q         <= MST_CPU;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cur_req) begin
                        if (s_data_gnt) begin
                            owner_q       <= cur_sel;
                            last_served_q <= cur_sel;
                            state_q       <= RESP;
                        end else begin
                            sel_q   <= cur_sel;
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!cur_req) begin
                        state_q <= IDLE;
                    end else if (s_data_gnt) begin
                        owner_q       <= sel_q;
                        last_served_q <= sel_q;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (s_data_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
